// File: rtl/ata_pkg.sv
// Shared definitions for the ATA PIO timing engine: FSM encoding, default
// mode-0 timing constants and the control-block select bit of the request address.
package ata_pkg;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_SETUP_ENC   = 3'd1;
  localparam logic [2:0] ST_PULSE_ENC   = 3'd2;
  localparam logic [2:0] ST_HOLD_ENC    = 3'd3;
  localparam logic [2:0] ST_RECOVER_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_SETUP   = ST_SETUP_ENC,
    ST_PULSE   = ST_PULSE_ENC,
    ST_HOLD    = ST_HOLD_ENC,
    ST_RECOVER = ST_RECOVER_ENC
  } state_e;

  localparam int T_SETUP_DEF   = 4;
  localparam int T_PULSE_DEF   = 15;
  localparam int T_HOLD_DEF    = 2;
  localparam int T_RECOVER_DEF = 9;
  localparam int IORDY_MAX_DEF = 1250;

  localparam int CNT_W = 16;

  // addr[3] = 1 addresses the control block (cs1), otherwise the command block (cs0)
  localparam int CS1_SEL_BIT = 3;

  function automatic logic is_ctrl_block(input logic [3:0] addr);
    return addr[CS1_SEL_BIT];
  endfunction

endpackage

// File: rtl/ata_pio_if.sv
// Requester-side handshake of the PIO engine: one register access per req/ack.
interface ata_pio_if;
  logic        req;
  logic        wr;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        ack;

  modport master (output req, wr, addr, din, input dout, ack);
  modport slave  (input req, wr, addr, din, output dout, ack);
endinterface

// File: rtl/ata_sync.sv
// Two-flop synchronizer with asynchronous active-high reset to RST_VAL.
module ata_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ata_pio.sv
// ATA PIO mode-0 timing engine: one timed register cycle per request.
// Optional ATA_PIO_IORDY_EN stretches the strobe while the drive holds IORDY low.
module ata_pio
  import ata_pkg::*;
#(
  parameter int T_SETUP   = T_SETUP_DEF,
  parameter int T_PULSE   = T_PULSE_DEF,
  parameter int T_HOLD    = T_HOLD_DEF,
  parameter int T_RECOVER = T_RECOVER_DEF,
  parameter int IORDY_MAX = IORDY_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ata_pio_if.slave    bus,
  inout  wire  [15:0] ata_d,
  output logic [2:0]  ata_a,
  output logic        ata_cs0_n,
  output logic        ata_cs1_n,
  output logic        ata_dior_n,
  output logic        ata_diow_n,
  input  logic        ata_iordy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [2:0]       a_q, a_d;
  logic             cs0_n_q, cs0_n_d, cs1_n_q, cs1_n_d;
  logic             dior_n_q, dior_n_d, diow_n_q, diow_n_d;
  logic             d_oe_q, d_oe_d;
  logic [15:0]      d_out_q, d_out_d;
  logic [15:0]      dout_q, dout_d;
  logic             ack_q, ack_d;
  logic             cnt_zero;
  logic             pulse_done;

`ifdef ATA_PIO_IORDY_EN
  logic iordy_s;
  logic ext_q, ext_d;

  // Reset to "ready" so a freshly reset engine never sees a phantom wait
  ata_sync #(.RST_VAL(1'b1)) u_iordy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ata_iordy),
    .q     (iordy_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ext_q <= 1'b0;
    else       ext_q <= ext_d;
  end
`else
  logic iordy_unused;
  localparam int IORDY_MAX_UNUSED = IORDY_MAX;
  assign iordy_unused = ata_iordy;
`endif

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    a_d        = a_q;
    cs0_n_d    = cs0_n_q;
    cs1_n_d    = cs1_n_q;
    dior_n_d   = dior_n_q;
    diow_n_d   = diow_n_q;
    d_oe_d     = d_oe_q;
    d_out_d    = d_out_q;
    dout_d     = dout_q;
    ack_d      = 1'b0;
    pulse_done = 1'b0;
`ifdef ATA_PIO_IORDY_EN
    ext_d      = ext_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          a_d     = bus.addr[2:0];
          cs0_n_d = is_ctrl_block(bus.addr);
          cs1_n_d = !is_ctrl_block(bus.addr);
          d_out_d = bus.din;
          d_oe_d  = bus.wr;
          cnt_d   = CNT_W'(T_SETUP - 1);
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_zero) begin
          dior_n_d = wr_q;
          diow_n_d = !wr_q;
          cnt_d    = CNT_W'(T_PULSE - 1);
          state_d  = ST_PULSE;
`ifdef ATA_PIO_IORDY_EN
          ext_d    = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_PULSE: begin
        pulse_done = cnt_zero;
`ifdef ATA_PIO_IORDY_EN
        // Past the nominal width the counter is reused as the IORDY timeout
        if (ext_q) begin
          pulse_done = iordy_s || cnt_zero;
        end else if (cnt_zero && !iordy_s) begin
          pulse_done = 1'b0;
          ext_d      = 1'b1;
          cnt_d      = CNT_W'(IORDY_MAX - 1);
        end
`endif
        if (pulse_done) begin
          dior_n_d = 1'b1;
          diow_n_d = 1'b1;
          if (!wr_q) dout_d = ata_d;
          cnt_d    = CNT_W'(T_HOLD - 1);
          state_d  = ST_HOLD;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_zero) begin
          cs0_n_d = 1'b1;
          cs1_n_d = 1'b1;
          a_d     = 3'd0;
          d_oe_d  = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = CNT_W'(T_RECOVER - 1);
          state_d = ST_RECOVER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RECOVER: begin
        if (cnt_zero) state_d = ST_IDLE;
        else          cnt_d   = cnt_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      a_q      <= 3'd0;
      cs0_n_q  <= 1'b1;
      cs1_n_q  <= 1'b1;
      dior_n_q <= 1'b1;
      diow_n_q <= 1'b1;
      d_oe_q   <= 1'b0;
      d_out_q  <= 16'h0000;
      dout_q   <= 16'h0000;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      a_q      <= a_d;
      cs0_n_q  <= cs0_n_d;
      cs1_n_q  <= cs1_n_d;
      dior_n_q <= dior_n_d;
      diow_n_q <= diow_n_d;
      d_oe_q   <= d_oe_d;
      d_out_q  <= d_out_d;
      dout_q   <= dout_d;
      ack_q    <= ack_d;
    end
  end

  assign ata_d      = d_oe_q ? d_out_q : 16'hzzzz;
  assign ata_a      = a_q;
  assign ata_cs0_n  = cs0_n_q;
  assign ata_cs1_n  = cs1_n_q;
  assign ata_dior_n = dior_n_q;
  assign ata_diow_n = diow_n_q;
  assign bus.dout   = dout_q;
  assign bus.ack    = ack_q;

endmodule

// File: tb/tb_ata_pio.sv
// Self-checking bench for ata_pio: cycle-level reference model plus directed
// literal checks of the mode-0 timing, IORDY stretching and mid-cycle reset.
module tb_ata_pio;

  localparam int TS     = 4;
  localparam int TP     = 15;
  localparam int TH     = 2;
  localparam int TR     = 9;
  localparam int IMAX   = 1250;
  localparam int PERIOD = TS + TP + TH + TR + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ata_iordy = 1'b1;
  wire  [15:0] ata_d;
  logic [2:0]  ata_a;
  logic        cs0_n, cs1_n, dior_n, diow_n;

  int tests  = 0;
  int failed = 0;

  ata_pio_if bus ();

  ata_pio #(
    .T_SETUP   (TS),
    .T_PULSE   (TP),
    .T_HOLD    (TH),
    .T_RECOVER (TR),
    .IORDY_MAX (IMAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ata_d      (ata_d),
    .ata_a      (ata_a),
    .ata_cs0_n  (cs0_n),
    .ata_cs1_n  (cs1_n),
    .ata_dior_n (dior_n),
    .ata_diow_n (diow_n),
    .ata_iordy  (ata_iordy)
  );

  always #10 clk = ~clk;

  // Reference model: position of the current transfer in clocks since its req was sampled
  bit          m_busy = 1'b0;
  int          m_k = 0;
  bit          m_wr = 1'b0;
  logic [3:0]  m_addr = 4'h0;
  logic [15:0] m_din = 16'h0000;
  logic [15:0] exp_dout = 16'h0000;
  logic [15:0] rd_val = 16'h0000;
  bit          model_en = 1'b0;

  logic        exp_sel, exp_strb, exp_drive, exp_ack;
  logic [15:0] tb_bus_val;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_k      <= 0;
      exp_dout <= 16'h0000;
    end else if (!m_busy) begin
      if (bus.req) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_wr   <= bus.wr;
        m_addr <= bus.addr;
        m_din  <= bus.din;
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == PERIOD - 1) m_busy <= 1'b0;
      if (!m_wr && (m_k + 1 == TS + TP)) exp_dout <= rd_val;
    end
  end

  always_comb begin
    exp_sel    = m_busy && (m_k < TS + TP + TH);
    exp_strb   = m_busy && (m_k >= TS) && (m_k < TS + TP);
    exp_drive  = exp_sel && m_wr;
    exp_ack    = m_busy && (m_k == TS + TP + TH);
    tb_bus_val = (exp_strb && !m_wr) ? rd_val : 16'h0000;
  end

  // Drive side: presents read data during the read strobe, parks the bus at 0 otherwise
  assign ata_d = exp_drive ? 16'hzzzz : tb_bus_val;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      failed++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_en && !reset) begin
      check_output("cs0_n",  cs0_n,  exp_sel ? m_addr[3] : 1'b1);
      check_output("cs1_n",  cs1_n,  exp_sel ? !m_addr[3] : 1'b1);
      check_output("ata_a",  ata_a,  exp_sel ? m_addr[2:0] : 3'd0);
      check_output("dior_n", dior_n, !(exp_strb && !m_wr));
      check_output("diow_n", diow_n, !(exp_strb && m_wr));
      check_output("ack",    bus.ack, exp_ack);
      check_output("dout",   bus.dout, exp_dout);
      check_output("ata_d",  ata_d, exp_drive ? m_din : tb_bus_val);
    end
  end

  task automatic apply_stimulus(input bit w, input logic [3:0] a, input logic [15:0] d);
    bus.req  = 1'b1;
    bus.wr   = w;
    bus.addr = a;
    bus.din  = d;
  endtask

  task automatic run_xfer(input bit w, input logic [3:0] a, input logic [15:0] d,
                          input logic [15:0] rv, output int width,
                          output logic [15:0] dout_at_ack, output logic [4:0] pins0);
    bit got;
    repeat (12) @(negedge clk);
    rd_val = rv;
    apply_stimulus(w, a, d);
    width = 0;
    got = 1'b0;
    dout_at_ack = 16'h0000;
    pins0 = 5'h00;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) pins0 = {cs0_n, cs1_n, ata_a};
      if ((w ? diow_n : dior_n) == 1'b0) width++;
      if (bus.ack) begin
        got = 1'b1;
        dout_at_ack = bus.dout;
      end
    end
    bus.req = 1'b0;
    check_output("xfer_ack_seen", got, 1'b1);
  endtask

  task automatic iordy_xfer(input int raise_after, output int width);
    bit got;
    repeat (12) @(negedge clk);
    ata_iordy = 1'b0;
    apply_stimulus(1'b1, 4'h5, 16'h0F0F);
    width = 0;
    got = 1'b0;
    for (int e = 0; e < 3000 && !got; e++) begin
      @(posedge clk);
      #1;
      if (e == raise_after) ata_iordy = 1'b1;
      if (!diow_n) width++;
      if (bus.ack) got = 1'b1;
    end
    bus.req = 1'b0;
    ata_iordy = 1'b1;
    check_output("iordy_ack_seen", got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          width;
    logic [15:0] dv;
    logic [4:0]  pins;
    int          falls [3];
    int          acks [3];
    int          nf, na, nack;
    bit          prev;

    bus.req  = 1'b0;
    bus.wr   = 1'b0;
    bus.addr = 4'h0;
    bus.din  = 16'h0000;

    repeat (3) @(negedge clk);
    check_output("rst_cs0_n",  cs0_n,  1'b1);
    check_output("rst_cs1_n",  cs1_n,  1'b1);
    check_output("rst_dior_n", dior_n, 1'b1);
    check_output("rst_diow_n", diow_n, 1'b1);
    check_output("rst_ata_a",  ata_a,  3'd0);
    check_output("rst_ack",    bus.ack, 1'b0);
    check_output("rst_dout",   bus.dout, 16'h0000);
    check_output("rst_ata_d",  ata_d, 16'h0000);
    reset = 1'b0;
    model_en = 1'b1;

    // Write to command register 7 with literal edge-by-edge expectations
    repeat (5) @(negedge clk);
    apply_stimulus(1'b1, 4'h7, 16'h00EC);
    for (int e = 0; e <= 22; e++) begin
      @(posedge clk);
      #1;
      case (e)
        0: begin
          check_output("wr_cs0_e0", cs0_n, 1'b0);
          check_output("wr_cs1_e0", cs1_n, 1'b1);
          check_output("wr_a_e0",   ata_a, 3'd7);
          check_output("wr_d_e0",   ata_d, 16'h00EC);
        end
        3:  check_output("wr_diow_e3",  diow_n, 1'b1);
        4:  check_output("wr_diow_e4",  diow_n, 1'b0);
        18: check_output("wr_diow_e18", diow_n, 1'b0);
        19: check_output("wr_diow_e19", diow_n, 1'b1);
        20: begin
          check_output("wr_d_e20",  ata_d, 16'h00EC);
          check_output("wr_ack_e20", bus.ack, 1'b0);
        end
        21: begin
          check_output("wr_ack_e21", bus.ack, 1'b1);
          check_output("wr_cs0_e21", cs0_n, 1'b1);
          check_output("wr_d_e21",   ata_d, 16'h0000);
          bus.req = 1'b0;
        end
        22: check_output("wr_ack_e22", bus.ack, 1'b0);
        default: ;
      endcase
    end

    // Reads: command block and control block
    run_xfer(1'b0, 4'h0, 16'hFFFF, 16'hBEEF, width, dv, pins);
    check_output("rd_width", width, TP);
    check_output("rd_dout",  dv, 16'hBEEF);
    check_output("rd_pins",  pins, {1'b0, 1'b1, 3'd0});

    run_xfer(1'b0, 4'hB, 16'h5A5A, 16'h1234, width, dv, pins);
    check_output("rd2_dout", dv, 16'h1234);
    check_output("rd2_pins", pins, {1'b1, 1'b0, 3'd3});

    run_xfer(1'b1, 4'hE, 16'h1357, 16'h0000, width, dv, pins);
    check_output("ctl_pins",  pins, {1'b1, 1'b0, 3'd6});
    check_output("ctl_width", width, TP);
    check_output("ctl_dout_kept", dv, 16'h1234);

    // Back-to-back: req held high across three transfers
    repeat (12) @(negedge clk);
    apply_stimulus(1'b1, 4'h2, 16'h1234);
    falls = '{0, 0, 0};
    acks  = '{0, 0, 0};
    nf = 0;
    na = 0;
    prev = 1'b1;
    for (int c = 0; c < 200 && na < 3; c++) begin
      @(posedge clk);
      #1;
      if (prev && !diow_n && nf < 3) begin
        falls[nf] = c;
        nf++;
      end
      prev = diow_n;
      if (bus.ack && na < 3) begin
        acks[na] = c;
        na++;
      end
    end
    bus.req = 1'b0;
    check_output("b2b_falls", nf, 3);
    check_output("b2b_acks", na, 3);
    check_output("b2b_first_fall", falls[0], TS);
    check_output("b2b_gap01", falls[1] - falls[0], PERIOD);
    check_output("b2b_gap12", falls[2] - falls[1], PERIOD);
    for (int i = 0; i < 3; i++) check_output("b2b_ack_pos", acks[i] - falls[i], TP + TH);

    // IORDY stretching (model paused: cycle length depends on the drive)
    repeat (12) @(negedge clk);
    model_en = 1'b0;
    iordy_xfer(TS + TP + 8, width);
`ifdef ATA_PIO_IORDY_EN
    check_range("iordy_short_width", width, TP + 10 - 2, TP + 10 + 2);
`else
    check_output("iordy_short_width", width, TP);
`endif
    iordy_xfer(-1, width);
`ifdef ATA_PIO_IORDY_EN
    check_output("iordy_stuck_width", width, TP + IMAX);
`else
    check_output("iordy_stuck_width", width, TP);
`endif
    repeat (45) @(negedge clk);
    model_en = 1'b1;

    // Asynchronous reset in the middle of a write strobe
    repeat (12) @(negedge clk);
    apply_stimulus(1'b1, 4'h1, 16'hC0DE);
    repeat (10) @(posedge clk);
    #5;
    check_output("pre_rst_diow", diow_n, 1'b0);
    reset = 1'b1;
    #1;
    check_output("mid_rst_diow", diow_n, 1'b1);
    check_output("mid_rst_cs0",  cs0_n, 1'b1);
    check_output("mid_rst_cs1",  cs1_n, 1'b1);
    check_output("mid_rst_a",    ata_a, 3'd0);
    check_output("mid_rst_d",    ata_d, 16'h0000);
    check_output("mid_rst_ack",  bus.ack, 1'b0);
    bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    nack = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ack) nack++;
    end
    check_output("rst_no_ack", nack, 0);

    run_xfer(1'b0, 4'h2, 16'hFFFF, 16'hA55A, width, dv, pins);
    check_output("post_rst_width", width, TP);
    check_output("post_rst_dout",  dv, 16'hA55A);

    repeat (35) @(negedge clk);
    model_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
